// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: funct5 codes and FSM state encoding.
package fpu_ctrl_pkg;

    localparam logic [4:0] FADD    = 5'b00000;
    localparam logic [4:0] FSUB    = 5'b00001;
    localparam logic [4:0] FMUL    = 5'b00010;
    localparam logic [4:0] FDIV    = 5'b00011;
    localparam logic [4:0] FSQRT   = 5'b01011;
    localparam logic [4:0] FSGNJ   = 5'b00100;
    localparam logic [4:0] FMINMAX = 5'b00101;
    localparam logic [4:0] FCMP    = 5'b10100;
    localparam logic [4:0] FCVT_WS = 5'b11000;
    localparam logic [4:0] FCVT_SW = 5'b11010;
    localparam logic [4:0] FMV_XW  = 5'b11100;
    localparam logic [4:0] FMV_WX  = 5'b11110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_latency_lut.sv
// Maps an F-extension funct5 to the datapath latency used to load the wait counter.
module fpu_latency_lut
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_SQRT = 12,
    parameter int unsigned LAT_CVT  = 2,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic [4:0]       funct5_i,
    output logic [CNT_W-1:0] load_o
);

    // Latency decode; anything not listed is a single-cycle misc op
    always_comb begin
        load_o = CNT_W'(LAT_MISC);
        case (funct5_i)
            FADD, FSUB:       load_o = CNT_W'(LAT_ADD);
            FMUL:             load_o = CNT_W'(LAT_MUL);
            FDIV:             load_o = CNT_W'(LAT_DIV);
            FSQRT:            load_o = CNT_W'(LAT_SQRT);
            FCVT_WS, FCVT_SW: load_o = CNT_W'(LAT_CVT);
            default:          load_o = CNT_W'(LAT_MISC);
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Launches one FP op on the handshake-free pipelined datapath, stalls E for its
// fixed latency, then presents the captured result with a valid until E advances.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_SQRT = 12,
    parameter int unsigned LAT_CVT  = 2,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] fpu_rd1,
    input  logic [31:0] fpu_rd2,
    input  logic [2:0]  fpu_rm,
    input  logic [4:0]  fpu_funct5,
    input  logic        flush_e,
    input  logic        hold,
    output logic        fpu_stall,
    output logic        fpu_valid,
    output logic [31:0] fpu_result,
    output logic        unit_start,
    output logic [31:0] unit_op_a,
    output logic [31:0] unit_op_b,
    output logic [2:0]  unit_rm,
    output logic [4:0]  unit_funct5,
    input  logic [31:0] unit_result
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   lat_load;
    logic               launch_c;
    logic               capture_c;

    logic               unit_start_q;
    logic [31:0]        unit_op_a_q, unit_op_b_q, fpu_result_q;
    logic [2:0]         unit_rm_q;
    logic [4:0]         unit_funct5_q;

    fpu_latency_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_CVT  (LAT_CVT),
        .LAT_MISC (LAT_MISC),
        .CNT_W    (CNT_W)
    ) u_lat (
        .funct5_i (fpu_funct5),
        .load_o   (lat_load)
    );

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; counter holds the full latency because start lands in the first BUSY cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req && !flush_e) begin
                    state_d = BUSY;
                    cnt_d   = lat_load;
                end
            end
            BUSY: begin
                if (flush_e) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush_e || !hold) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall/valid decode and launch/capture strobes
    always_comb begin
        launch_c  = 1'b0;
        capture_c = 1'b0;
        fpu_stall = 1'b0;
        fpu_valid = 1'b0;
        case (state_q)
            IDLE: begin
                launch_c  = req && !flush_e;
                fpu_stall = launch_c;
            end
            BUSY: begin
                fpu_stall = 1'b1;
                capture_c = !flush_e && (cnt_q == '0);
            end
            DONE: begin
                fpu_valid = 1'b1;
            end
            default: begin
                fpu_stall = 1'b0;
            end
        endcase
    end

    // Operand holding registers, launch pulse and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_start_q  <= 1'b0;
            unit_op_a_q   <= '0;
            unit_op_b_q   <= '0;
            unit_rm_q     <= '0;
            unit_funct5_q <= '0;
            fpu_result_q  <= '0;
        end else begin
            unit_start_q <= launch_c;
            if (launch_c) begin
                unit_op_a_q   <= fpu_rd1;
                unit_op_b_q   <= fpu_rd2;
                unit_rm_q     <= fpu_rm;
                unit_funct5_q <= fpu_funct5;
            end
            if (capture_c) begin
                fpu_result_q <= unit_result;
            end
        end
    end

    assign unit_start  = unit_start_q;
    assign unit_op_a   = unit_op_a_q;
    assign unit_op_b   = unit_op_b_q;
    assign unit_rm     = unit_rm_q;
    assign unit_funct5 = unit_funct5_q;
    assign fpu_result  = fpu_result_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-indexed reference model.
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] fpu_rd1, fpu_rd2;
    logic [2:0]  fpu_rm;
    logic [4:0]  fpu_funct5;
    logic        flush_e, hold;
    logic        fpu_stall, fpu_valid;
    logic [31:0] fpu_result;
    logic        unit_start;
    logic [31:0] unit_op_a, unit_op_b;
    logic [2:0]  unit_rm;
    logic [4:0]  unit_funct5;
    logic [31:0] unit_result;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;
    logic [31:0] res_at [int];

    fpu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .fpu_rd1     (fpu_rd1),
        .fpu_rd2     (fpu_rd2),
        .fpu_rm      (fpu_rm),
        .fpu_funct5  (fpu_funct5),
        .flush_e     (flush_e),
        .hold        (hold),
        .fpu_stall   (fpu_stall),
        .fpu_valid   (fpu_valid),
        .fpu_result  (fpu_result),
        .unit_start  (unit_start),
        .unit_op_a   (unit_op_a),
        .unit_op_b   (unit_op_b),
        .unit_rm     (unit_rm),
        .unit_funct5 (unit_funct5),
        .unit_result (unit_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input logic [4:0] f);
        case (f)
            5'b00000, 5'b00001: return 3;
            5'b00010:           return 2;
            5'b00011:           return 10;
            5'b01011:           return 12;
            5'b11000, 5'b11010: return 2;
            default:            return 1;
        endcase
    endfunction

    // Stand-in arithmetic for the datapath; one pinned real fadd result
    function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f);
        if (a == 32'h3F800000 && b == 32'h40000000 && f == 5'b00000) return 32'h40400000;
        return (a ^ {b[15:0], b[31:16]}) + {27'd0, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Datapath stub: result appears exactly LAT cycles after start, garbage otherwise
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (res_at.exists(cyc)) unit_result = res_at[cyc];
        else                    unit_result = $urandom;
    end

    // Reference model: tracks the op by absolute cycle numbers
    int          m_mode = 0;   // 0 free, 1 waiting on datapath, 2 result presented
    int          m_launch = 0, m_end = 0;
    logic [31:0] m_res = '0, e_res = '0, e_a = '0, e_b = '0;
    logic [2:0]  e_rm = '0;
    logic [4:0]  e_f5 = '0;

    always @(negedge clk) begin
        logic exp_stall, exp_valid, exp_start;
        if (unit_start === 1'b1)
            res_at[cyc + lat_of(unit_funct5)] = dp_fn(unit_op_a, unit_op_b, unit_funct5);
        exp_stall = (m_mode == 1) || (m_mode == 0 && req && !flush_e);
        exp_valid = (m_mode == 2);
        exp_start = (m_mode == 1) && (cyc == m_launch + 1);
        if (chk_en) begin
            chk("fpu_stall",   32'(fpu_stall),   32'(exp_stall));
            chk("fpu_valid",   32'(fpu_valid),   32'(exp_valid));
            chk("unit_start",  32'(unit_start),  32'(exp_start));
            chk("fpu_result",  fpu_result,       e_res);
            chk("unit_op_a",   unit_op_a,        e_a);
            chk("unit_op_b",   unit_op_b,        e_b);
            chk("unit_rm",     32'(unit_rm),     32'(e_rm));
            chk("unit_funct5", 32'(unit_funct5), 32'(e_f5));
        end
        if (rst) begin
            m_mode = 0; e_res = '0; e_a = '0; e_b = '0; e_rm = '0; e_f5 = '0;
        end else begin
            case (m_mode)
                0: if (req && !flush_e) begin
                    m_launch = cyc;
                    m_end    = cyc + 1 + lat_of(fpu_funct5);
                    e_a = fpu_rd1; e_b = fpu_rd2; e_rm = fpu_rm; e_f5 = fpu_funct5;
                    m_res  = dp_fn(fpu_rd1, fpu_rd2, fpu_funct5);
                    m_mode = 1;
                end
                1: if (flush_e) m_mode = 0;
                   else if (cyc == m_end) begin
                       e_res  = m_res;
                       m_mode = 2;
                   end
                default: if (flush_e || !hold) m_mode = 0;
            endcase
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 0; req = 0; flush_e = 0; hold = 0;
        end
    endtask

    // One op issued at t=0, optional flush at t=flush_at, hold for hold_n valid cycles
    task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int hold_n, input int ncyc,
                          output int n_stall, output int n_start, output int t_start,
                          output int n_valid, output int t_valid,
                          output logic [31:0] res, output bit stable);
        n_stall = 0; n_start = 0; t_start = -1; n_valid = 0; t_valid = -1;
        res = '0; stable = 1;
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk); #1;
            req = (t == 0); fpu_funct5 = f5; fpu_rd1 = a; fpu_rd2 = b; fpu_rm = 3'd2;
            flush_e = (t == flush_at); hold = (n_valid < hold_n);
            #2;
            if (fpu_stall) n_stall++;
            if (unit_start) begin n_start++; if (t_start < 0) t_start = t; end
            if (fpu_valid) begin
                if (t_valid < 0) t_valid = t;
                else if (fpu_result != res) stable = 0;
                res = fpu_result;
                n_valid++;
            end
        end
        req = 0; flush_e = 0; hold = 0;
    endtask

    initial begin
        int ns, nst, ts, nv, tv;
        logic [31:0] r;
        bit st;
        int starts[$];

        rst = 1; req = 0; flush_e = 0; hold = 0;
        fpu_rd1 = '0; fpu_rd2 = '0; fpu_rm = '0; fpu_funct5 = '0; unit_result = '0;
        repeat (3) @(posedge clk);
        #1; rst = 0; chk_en = 1;
        #2;
        chk("reset fpu_valid",  32'(fpu_valid),  32'd0);
        chk("reset unit_start", 32'(unit_start), 32'd0);
        chk("reset fpu_result", fpu_result,      32'd0);
        chk("reset unit_op_a",  unit_op_a,       32'd0);

        // fadd: five stall cycles, start at T1, valid at T5
        idle(2);
        run_op(FADD, 32'h3F800000, 32'h40000000, -1, 0, 8, ns, nst, ts, nv, tv, r, st);
        chk("fadd stall cycles", 32'(ns), 32'd5);
        chk("fadd start count",  32'(nst), 32'd1);
        chk("fadd start time",   32'(ts), 32'd1);
        chk("fadd valid time",   32'(tv), 32'd5);
        chk("fadd valid count",  32'(nv), 32'd1);
        chk("fadd result",       r, 32'h40400000);

        // fdiv held two extra cycles in DONE
        idle(2);
        run_op(FDIV, 32'h12345678, 32'h9ABCDEF0, -1, 2, 17, ns, nst, ts, nv, tv, r, st);
        chk("fdiv stall cycles", 32'(ns), 32'd12);
        chk("fdiv start count",  32'(nst), 32'd1);
        chk("fdiv valid count",  32'(nv), 32'd3);
        chk("fdiv result stable", 32'(st), 32'd1);
        chk("fdiv result",       r, dp_fn(32'h12345678, 32'h9ABCDEF0, FDIV));

        // fmul flushed in its second BUSY cycle, then fsgnj
        idle(2);
        run_op(FMUL, 32'hCAFEBABE, 32'h0BADF00D, 2, 0, 8, ns, nst, ts, nv, tv, r, st);
        chk("fmul flushed valid", 32'(nv), 32'd0);
        chk("fmul flushed start", 32'(nst), 32'd1);
        run_op(FSGNJ, 32'h11112222, 32'h33334444, -1, 0, 6, ns, nst, ts, nv, tv, r, st);
        chk("fsgnj stall cycles", 32'(ns), 32'd3);
        chk("fsgnj valid time",   32'(tv), 32'd3);
        chk("fsgnj result",       r, dp_fn(32'h11112222, 32'h33334444, FSGNJ));

        // req with flush in IDLE does nothing
        idle(2);
        run_op(FADD, 32'h1, 32'h2, 0, 0, 4, ns, nst, ts, nv, tv, r, st);
        chk("flushed req start", 32'(nst), 32'd0);
        chk("flushed req stall", 32'(ns), 32'd0);

        // reset mid-fsqrt when the counter has reached 5
        idle(2);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            req = (t == 0); fpu_funct5 = FSQRT; fpu_rd1 = 32'h40800000; fpu_rd2 = 32'h0;
            rst = (t == 8);
        end
        #2;
        chk("rst unit_start",  32'(unit_start),  32'd0);
        chk("rst fpu_stall",   32'(fpu_stall),   32'd0);
        chk("rst fpu_valid",   32'(fpu_valid),   32'd0);
        chk("rst fpu_result",  fpu_result,       32'd0);
        chk("rst unit_op_a",   unit_op_a,        32'd0);
        chk("rst unit_funct5", 32'(unit_funct5), 32'd0);
        nv = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #3;
            if (fpu_valid) nv++;
        end
        chk("stale result valid", 32'(nv), 32'd0);

        // back-to-back fadd then fcvt.w.s with req held
        idle(2);
        nv = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            req = (nv < 2);
            fpu_funct5 = (nv >= 1) ? FCVT_WS : FADD;
            fpu_rd1 = 32'h00000007 + 32'(nv); fpu_rd2 = 32'h00000100;
            #2;
            if (unit_start) starts.push_back(t);
            if (fpu_valid) nv++;
        end
        chk("b2b start count", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) chk("b2b start gap", 32'(starts[1] - starts[0]), 32'd6);
        chk("b2b valid count", 32'(nv), 32'd2);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int pick;
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 299) == 0);
            req     = ($urandom_range(0, 1) == 1);
            flush_e = ($urandom_range(0, 11) == 0);
            hold    = ($urandom_range(0, 2) == 0);
            fpu_rd1 = $urandom; fpu_rd2 = $urandom; fpu_rm = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            case (pick)
                0: fpu_funct5 = FADD;
                1: fpu_funct5 = FSUB;
                2: fpu_funct5 = FMUL;
                3: fpu_funct5 = FDIV;
                4: fpu_funct5 = FSQRT;
                5: fpu_funct5 = FCVT_WS;
                6: fpu_funct5 = FCVT_SW;
                7: fpu_funct5 = FMINMAX;
                default: fpu_funct5 = 5'($urandom_range(0, 31));
            endcase
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
